// File: rtl/sync_fifo_rd_adapter.sv
// Read-side adapter for sync_fifo: turns rd_en/empty with one-cycle dout latency into a valid/ready stream.
// Optional SYNC_FIFO_RD_ADAPTER_STATS_EN adds beat and stall counters.
module sync_fifo_rd_adapter #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] fifo_dout_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o
`ifdef SYNC_FIFO_RD_ADAPTER_STATS_EN
    ,
    output logic [31:0]           beat_count_o,
    output logic [31:0]           stall_count_o
`endif
);

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_TWO   = 2'd2;

    logic [1:0]            count_q, count_d;
    logic                  inflight_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  pop;
    logic [2:0]            occ_next;

    assign m_valid_o = (count_q != CNT_EMPTY);
    assign pop       = m_valid_o & m_ready_i;
    assign m_data_o  = buf_q[rd_ptr_q];

    // Occupancy once this cycle's capture and pop settle; a read is only
    // issued if the word returning next cycle is guaranteed a free slot.
    assign occ_next     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en_o = rst_i & ~fifo_empty_i & (occ_next < 3'd2);

    always_comb begin
        count_d = CNT_EMPTY;
        case (occ_next)
            3'd0:    count_d = CNT_EMPTY;
            3'd1:    count_d = CNT_ONE;
            default: count_d = CNT_TWO;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!rst_i) begin
            count_q    <= CNT_EMPTY;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= fifo_rd_en_o;
            if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
            if (pop)        rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Buffer storage carries no reset; a stray write during reset is never read.
    always_ff @(posedge clock_i) begin
        if (inflight_q) buf_q[wr_ptr_q] <= fifo_dout_i;
    end

`ifdef SYNC_FIFO_RD_ADAPTER_STATS_EN
    logic [31:0] beat_q, stall_q;

    always_ff @(posedge clock_i) begin
        if (!rst_i) begin
            beat_q  <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            if (pop)                    beat_q  <= beat_q + 32'd1;
            if (m_valid_o & ~m_ready_i) stall_q <= stall_q + 32'd1;
        end
    end

    assign beat_count_o  = beat_q;
    assign stall_count_o = stall_q;
`endif

endmodule

// File: tb/tb_sync_fifo_rd_adapter.sv
// Bench for sync_fifo_rd_adapter: queue-based upstream FIFO and output-buffer model, directed plus random phases.
module tb_sync_fifo_rd_adapter;
    localparam int W = 64;

    logic         clock = 1'b0;
    logic         rst;
    logic [W-1:0] fifo_dout;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
`ifdef SYNC_FIFO_RD_ADAPTER_STATS_EN
    logic [31:0]  beat_count;
    logic [31:0]  stall_count;
`endif

    always #5 clock = ~clock;

    sync_fifo_rd_adapter #(.DATA_WIDTH(W)) dut (
        .clock_i      (clock),
        .rst_i        (rst),
        .fifo_dout_i  (fifo_dout),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data)
`ifdef SYNC_FIFO_RD_ADAPTER_STATS_EN
        ,
        .beat_count_o (beat_count),
        .stall_count_o(stall_count)
`endif
    );

    logic [W-1:0] fq[$];    // upstream FIFO contents
    logic [W-1:0] rbuf[$];  // words the adapter should be holding
    logic [W-1:0] outq[$];  // words accepted by the consumer
    logic [W-1:0] sent[$];  // words pushed into the FIFO, in order
    bit           rinfl;
    bit           obs_valid;
    int           n_chk, n_fail, rd_pulses;
    int unsigned  exp_beat, exp_stall;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs before the edge, then advance model and FIFO.
    task automatic step();
        bit pop, exp_v, exp_rd, rd_seen;
        fifo_empty = (fq.size() == 0);
        #1;
        exp_v  = (rbuf.size() != 0);
        pop    = exp_v && m_ready;
        exp_rd = rst && !fifo_empty && ((rbuf.size() + int'(rinfl) - int'(pop)) < 2);
        chk("m_valid", m_valid, exp_v);
        chk("fifo_rd_en", fifo_rd_en, exp_rd);
        chk("rd_while_empty", fifo_rd_en & fifo_empty, 0);
        if (exp_v) chk("m_data", m_data, rbuf[0]);
        obs_valid = m_valid;
        rd_seen   = fifo_rd_en;
        if (rd_seen) rd_pulses++;
        @(posedge clock);
        #1;
        if (!rst) begin
            rbuf.delete();
            rinfl     = 0;
            exp_beat  = 0;
            exp_stall = 0;
        end else begin
            if (pop) begin
                outq.push_back(rbuf.pop_front());
                exp_beat++;
            end
            if (exp_v && !m_ready) exp_stall++;
            if (rinfl) rbuf.push_back(fifo_dout);
            rinfl = exp_rd;
        end
        if (rd_seen && fq.size() != 0) fifo_dout = fq.pop_front();
`ifdef SYNC_FIFO_RD_ADAPTER_STATS_EN
        chk("beat_count", beat_count, exp_beat);
        chk("stall_count", stall_count, exp_stall);
`endif
    endtask

    task automatic load(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + W'(i));
            sent.push_back(base + W'(i));
        end
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, outq.size(), sent.size());
        for (int i = 0; i < outq.size() && i < sent.size(); i++)
            chk({tag, "_word"}, outq[i], sent[i]);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fq.delete();
        step();
        rst = 1'b1;
        outq.delete();
        sent.delete();
    endtask

    initial begin
        int first_v, nvalid, last_v;
        n_chk = 0; n_fail = 0; rd_pulses = 0;
        exp_beat = 0; exp_stall = 0; rinfl = 0;
        rst = 1'b0; m_ready = 1'b1; fifo_dout = '0; fifo_empty = 1'b1;
        @(posedge clock);
        #1;

        // Reset held with a non-empty FIFO, then streaming at full rate
        load(64'h10, 8);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("rd_en_after_release", fifo_rd_en, 1);
        first_v = -1; nvalid = 0; last_v = -1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (obs_valid) begin
                if (first_v < 0) first_v = i;
                nvalid++;
                last_v = i;
            end
        end
        chk("first_valid_cycle", first_v, 2);
        chk("valid_cycles", nvalid, 8);
        chk("last_valid_cycle", last_v, 9);
        cmp_stream("stream");

        // Backpressure: two reads land, head word held, then drain
        do_reset();
`ifdef SYNC_FIFO_RD_ADAPTER_STATS_EN
        chk("beat_after_reset", beat_count, 0);
        chk("stall_after_reset", stall_count, 0);
`endif
        load(64'h10, 8);
        m_ready = 1'b0;
        rd_pulses = 0;
        repeat (7) step();
        chk("bp_rd_pulses", rd_pulses, 2);
        chk("bp_valid", m_valid, 1);
        chk("bp_head", m_data, 64'h10);
        m_ready = 1'b1;
        repeat (14) step();
        cmp_stream("backpressure");
`ifdef SYNC_FIFO_RD_ADAPTER_STATS_EN
        chk("bp_beats", beat_count, 8);
        chk("bp_stalls", stall_count, 5);
`endif

        // Alternating ready
        do_reset();
        load(64'h30, 8);
        for (int i = 0; i < 30; i++) begin
            m_ready = i[0];
            step();
        end
        m_ready = 1'b1;
        repeat (4) step();
        cmp_stream("alternate");

        // Mid-stream reset after two pops
        do_reset();
        load(64'h10, 8);
        m_ready = 1'b1;
        for (int i = 0; i < 20 && outq.size() < 2; i++) step();
        chk("midrst_two_popped", outq.size(), 2);
        m_ready = 1'b0;
        rst = 1'b0;
        fq.delete();
        step();
        rst = 1'b1;
        chk("valid_after_rst", m_valid, 0);
        outq.delete();
        sent.delete();
        load(64'h20, 4);
        m_ready = 1'b1;
        repeat (12) step();
        cmp_stream("midrst");

        // Random traffic and random consumer stalls
        do_reset();
        for (int i = 0; i < 400; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                logic [W-1:0] w;
                w = {$urandom, $urandom};
                fq.push_back(w);
                sent.push_back(w);
            end
            step();
        end
        m_ready = 1'b1;
        repeat (10) step();
        cmp_stream("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
